// File: rtl/spu_lsu_initiator.sv
// Odd-pipe quadword load/store initiator (unit 7): forms the EA, runs a req/ack access to local store.
// Optional index bounds fault against LS_QWORDS when LSU_BOUNDS_CHECK_EN is defined.
module spu_lsu_initiator #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LS_QWORDS = 2001,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned REG_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_unit,
  input  logic              op_is_store,
  input  logic [31:0]       op_base,
  input  logic [31:0]       op_offset,
  input  logic [127:0]      op_wdata,
  input  logic [REG_W-1:0]  op_rc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ack,
  input  logic [127:0]      mem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic [127:0]      wb_data,
  output logic              st_done,
  output logic              err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {Idle, Req, Done} stateT;

  stateT             state;
  logic [CntW-1:0]   reqCnt;
  logic [REG_W-1:0]  rcQ;
  logic [31:0]       eaSum;
  logic [ADDR_W-1:0] eaIdx;
  logic              boundsFault;
  logic              accept;

  if (TIMEOUT < 1 || 64'(LS_QWORDS) > (64'd1 << ADDR_W)) begin : gBadParams
    $error("spu_lsu_initiator: TIMEOUT must be >= 1 and LS_QWORDS must fit in ADDR_W");
  end

  // Dropping the low nibble aligns the EA to a quadword; truncation wraps the index.
  assign eaSum  = op_base + op_offset;
  assign eaIdx  = ADDR_W'(eaSum >> 4);
  assign accept = op_valid && (op_unit == 3'd7);

`ifdef LSU_BOUNDS_CHECK_EN
  assign boundsFault = 32'(eaIdx) >= LS_QWORDS;
`else
  assign boundsFault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= Idle;
      reqCnt    <= '0;
      rcQ       <= '0;
      op_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      st_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      st_done  <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        Idle: begin
          if (accept) begin
            mem_we    <= op_is_store;
            mem_addr  <= eaIdx;
            mem_wdata <= op_wdata;
            rcQ       <= op_rc;
            reqCnt    <= '0;
            // A faulting op is consumed without touching memory.
            if (boundsFault) begin
              err <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              op_ready <= 1'b0;
              state    <= Req;
            end
          end
        end
        Req: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= Done;
            if (mem_we) begin
              st_done <= 1'b1;
            end else begin
              wb_valid <= 1'b1;
              wb_reg   <= rcQ;
              wb_data  <= mem_rdata;
            end
          end else if (reqCnt == CntW'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            op_ready <= 1'b1;
            state    <= Idle;
          end else begin
            reqCnt <= reqCnt + CntW'(1);
          end
        end
        Done: begin
          op_ready <= 1'b1;
          state    <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_lsu_initiator.sv
// Bench for spu_lsu_initiator: directed cases plus random ops against a quadword memory model.
module tb_spu_lsu_initiator;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned LS_QW   = 2001;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned REG_W   = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid, op_ready, op_is_store;
  logic [2:0]        op_unit;
  logic [31:0]       op_base, op_offset;
  logic [127:0]      op_wdata;
  logic [REG_W-1:0]  op_rc;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_wdata, mem_rdata;
  logic              wb_valid, st_done, err;
  logic [REG_W-1:0]  wb_reg;
  logic [127:0]      wb_data;

  int passCnt = 0;
  int totalCnt = 0;

  logic [127:0] memModel [int unsigned];

  spu_lsu_initiator #(
    .ADDR_W(ADDR_W), .LS_QWORDS(LS_QW), .TIMEOUT(TIMEOUT), .REG_W(REG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_unit(op_unit), .op_is_store(op_is_store),
    .op_base(op_base), .op_offset(op_offset), .op_wdata(op_wdata), .op_rc(op_rc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .st_done(st_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Quadword index from plain arithmetic: byte EA mod 2^32, divided by 16, mod 2^ADDR_W.
  function automatic int unsigned refIdx(input logic [31:0] b, input logic [31:0] o);
    longint unsigned s;
    s = (64'(b) + 64'(o)) % 64'h1_0000_0000;
    return int'((s / 16) % (64'd1 << ADDR_W));
  endfunction

  task automatic driveOp(input bit isSt, input logic [2:0] unit, input logic [31:0] b,
                         input logic [31:0] o, input logic [127:0] wd, input logic [REG_W-1:0] rc);
    op_valid = 1'b1; op_unit = unit; op_is_store = isSt;
    op_base = b; op_offset = o; op_wdata = wd; op_rc = rc;
  endtask

  task automatic doOp(input bit isSt, input logic [31:0] b, input logic [31:0] o,
                      input logic [127:0] wd, input logic [REG_W-1:0] rc, input int waits);
    int unsigned idx;
    logic [127:0] expRd;
    idx = refIdx(b, o);
    if (!memModel.exists(idx)) memModel[idx] = rand128();
    expRd = memModel[idx];
    chk("op_ready_idle", op_ready, 1);
    driveOp(isSt, 3'd7, b, o, wd, rc);
    step();
    op_valid = 1'b0;
    op_wdata = rand128();
    op_base  = $urandom;
    for (int i = 0; i <= waits; i++) begin
      chk("mem_req_held", mem_req, 1);
      chk("mem_addr", mem_addr, 128'(idx));
      chk("mem_we", mem_we, isSt);
      if (isSt) chk("mem_wdata", mem_wdata, wd);
      chk("op_ready_busy", op_ready, 0);
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? expRd : rand128();
      step();
    end
    mem_ack = 1'b0;
    mem_rdata = rand128();
    chk("mem_req_drop", mem_req, 0);
    chk("wb_valid", wb_valid, !isSt);
    chk("st_done", st_done, isSt);
    chk("err_none", err, 0);
    chk("op_ready_done", op_ready, 0);
    if (!isSt) begin
      chk("wb_reg", wb_reg, rc);
      chk("wb_data", wb_data, expRd);
    end else begin
      memModel[idx] = wd;
    end
    step();
    chk("op_ready_back", op_ready, 1);
    chk("wb_valid_pulse", wb_valid, 0);
    chk("st_done_pulse", st_done, 0);
  endtask

  initial begin
    bit isSt;
    logic [31:0] b, o;
    reset = 1'b1;
    op_valid = 1'b0; op_unit = '0; op_is_store = 1'b0; op_base = '0; op_offset = '0;
    op_wdata = '0; op_rc = '0; mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_reg", wb_reg, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_st_done", st_done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Store then load of the same quadword, zero-wait memory.
    doOp(1'b1, 32'h20, 32'h0, 128'd120, 7'd0, 0);
    doOp(1'b0, 32'h2C, 32'h0, 128'd0, 7'd5, 0);

    // Ack delayed by 4 cycles.
    doOp(1'b0, 32'h100, 32'h40, 128'd0, 7'd17, 4);
    doOp(1'b1, 32'h300, 32'h7, rand128(), 7'd0, 4);

    // Address wrap.
    doOp(1'b0, 32'hFFFF_FFF0, 32'h20, 128'd0, 7'd9, 1);

    // Wrong unit ID is ignored.
    driveOp(1'b0, 3'd3, 32'h40, 32'h0, 128'd0, 7'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("unit_filter_req", mem_req, 0);
      chk("unit_filter_ready", op_ready, 1);
    end
    op_valid = 1'b0;

    // Timeout: never acknowledge.
    driveOp(1'b0, 3'd7, 32'h80, 32'h0, 128'd0, 7'd3);
    step();
    op_valid = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk("to_req_held", mem_req, 1);
      chk("to_no_err", err, 0);
      step();
    end
    chk("to_req_drop", mem_req, 0);
    chk("to_err", err, 1);
    chk("to_no_wb", wb_valid, 0);
    chk("to_ready", op_ready, 1);
    step();
    chk("to_err_pulse", err, 0);
    chk("to_no_wb2", wb_valid, 0);
    chk("to_req_idle", mem_req, 0);

    // Reset while a request is outstanding.
    driveOp(1'b1, 3'd7, 32'h50, 32'h0, rand128(), 7'd0);
    step();
    op_valid = 1'b0;
    chk("rr_req", mem_req, 1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("rr_req_drop", mem_req, 0);
    chk("rr_ready", op_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_no_wb", wb_valid, 0);
      chk("rr_no_st", st_done, 0);
      chk("rr_no_err", err, 0);
      chk("rr_no_req", mem_req, 0);
    end
    mem_ack = 1'b0;

`ifdef LSU_BOUNDS_CHECK_EN
    driveOp(1'b0, 3'd7, 32'(LS_QW * 16), 32'h0, 128'd0, 7'd2);
    step();
    op_valid = 1'b0;
    chk("bnd_no_req", mem_req, 0);
    chk("bnd_err", err, 1);
    chk("bnd_no_wb", wb_valid, 0);
    step();
    chk("bnd_err_pulse", err, 0);
    chk("bnd_ready", op_ready, 1);
    chk("bnd_no_req2", mem_req, 0);
`else
    doOp(1'b0, 32'(LS_QW * 16), 32'h0, 128'd0, 7'd2, 0);
`endif

    // Random ops with random wait states and idle gaps.
    for (int n = 0; n < 30; n++) begin
      isSt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom;
        o = $urandom;
      end else begin
        b = 32'($urandom_range(0, 40) * 16 + $urandom_range(0, 15));
        o = 32'($urandom_range(0, 64));
      end
      doOp(isSt, b, o, rand128(), 7'($urandom), $urandom_range(0, 6));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mem_ack = 1'($urandom_range(0, 1));
        step();
        chk("gap_req", mem_req, 0);
        chk("gap_wb", wb_valid, 0);
      end
      mem_ack = 1'b0;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/spu_lsu_initiator.md
Name: spu_lsu_initiator

Overview:
- Odd-pipe load/store initiator for unit ID 7.
- Accepts one quadword load or store op from issue, forms the effective address, and drives a req/ack request to the local-store data memory.
- For loads, captures read data and pulses a register-file writeback.
- Sits between the odd pipe's operand stage and the data memory, i.e. it is the requesting end of the memory's load/store interface.

Parameters:
- ADDR_W, 11, width of quadword index sent to memory (2^11 ≥ 2001 quadwords).
- LS_QWORDS, 2001, number of implemented quadwords; used only with the optional feature.
- TIMEOUT, 15, max cycles mem_req is held without mem_ack before abort; must be ≥1.
- REG_W, 7, destination register index width (128 registers).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  issue presents an op.
- op_ready  out  1  initiator can accept an op this cycle.
- op_unit  in  3  unit ID; op is accepted only when it equals 7.
- op_is_store  in  1  1 = store RT to memory; 0 = load into RC.
- op_base  in  32  RA preferred-slot word.
- op_offset  in  32  byte offset, already scaled.
- op_wdata  in  128  store data.
- op_rc  in  REG_W  load destination register.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  quadword index.
- mem_wdata  out  128  write data.
- mem_ack  in  1  memory completes the request; mem_rdata is valid in the same cycle for reads.
- mem_rdata  in  128  read data.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_reg  out  REG_W  writeback register.
- wb_data  out  128  writeback data.
- st_done  out  1  one-cycle store-complete pulse.
- err  out  1  one-cycle error pulse (timeout or bounds fault).

Behaviour:
- Reset (asynchronous):
  - State returns to IDLE.
  - Every output is 0 except op_ready, which is 1.
  - All registers clear, including the timeout counter and the captured op.
  - Asserting reset mid-request drops mem_req immediately; the op is lost and produces no wb_valid, st_done or err.
- IDLE:
  - op_ready=1.
  - Accept when op_valid=1 and op_unit=7. Capture the op, compute EA=(op_base+op_offset) mod 2^32, then EA &= ~0xF. mem_addr = EA[ADDR_W+3:4], which wraps modulo 2^ADDR_W.
  - Next state is REQ.
  - op_valid with op_unit≠7 is ignored; op_ready stays 1.
- REQ:
  - op_ready=0. mem_req=1, and mem_we, mem_addr and mem_wdata stay stable until ack.
  - Timeout counter starts at 0 on entry and increments each cycle mem_ack=0.
  - When mem_ack=1:
    - Load: register mem_rdata, go to DONE.
    - Store: go to DONE.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, pulse err next cycle, go to IDLE. No writeback occurs.
  - mem_ack in IDLE or DONE is ignored.
- DONE (1 cycle):
  - Load: wb_valid=1 with wb_reg=captured RC and wb_data=captured rdata.
  - Store: st_done=1.
  - mem_req=0, op_ready=0. Next state is IDLE.
- Latency:
  - Op accepted at cycle 0; mem_req is high from cycle 1.
  - Ack at cycle k gives wb_valid/st_done at cycle k+1, and op_ready=1 at cycle k+2.
  - Zero-wait memory therefore yields a 3-cycle op-to-op throughput.
- Outputs are registered. wb_data and wb_reg hold their last values when wb_valid=0.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- When defined:
  - In IDLE, if the computed index ≥ LS_QWORDS, the op is still accepted but no mem_req is issued.
  - The next cycle pulses err=1 and returns to IDLE; no wb_valid or st_done.
- When undefined:
  - No check is made; the truncated index is always issued.

Test Plan:
- Store then load, zero-wait ack:
  - Store with base=0x20, offset=0x0, wdata=120 → mem_addr=2, mem_we=1, st_done at cycle 2.
  - Load with base=0x2C, rc=5 and mem_rdata=120 → mem_addr=2, wb_valid with wb_reg=5, wb_data=120.
- Wait-state: ack delayed 4 cycles → mem_req, mem_addr and mem_wdata stay stable for 5 cycles; wb_valid fires exactly 1 cycle after ack.
- Timeout: never ack → mem_req held TIMEOUT cycles, then dropped; err pulses once; op_ready returns; no wb_valid.
- Unit filter and wrap:
  - op_unit=3 → no mem_req.
  - base=0xFFFFFFF0, offset=0x20 → EA=0x10, mem_addr=1.
- Reset mid-REQ: reset asserted while mem_req=1 → mem_req=0 immediately; op_ready=1; no wb_valid, st_done or err after release.
- Bounds (LSU_BOUNDS_CHECK_EN defined): load with base=2001*16 → no mem_req, err pulse. Undefined → mem_addr=2001.
